ws2812_serializer: RTL and testbench
====================================

# ws2812_serializer

Serial output stage of the SPI-to-NeoPixel path. On a start pulse it fetches one GRB pixel per LED from the upstream frame buffer through a request/address handshake and drives the WS2812 single-wire waveform on `do_o`. It then holds the line low for the latch interval. It sits directly downstream of the SPI frame-buffer wrapper, which supplies pixel colours from its dual-port RAM bank and pulses `start_i` when the SPI transaction ends.

## Interface
Parameters:
- NUM_LEDS, 8, maximum LEDs per frame; must be ≥ 2.
- SYSTEM_CLOCK, 50000000, clk_i frequency in Hz.

Derived localparams (integer division, truncating):
- T0H_CYC = SYSTEM_CLOCK/2500000, a 0.4 µs high time.
- T1H_CYC = SYSTEM_CLOCK/1250000, a 0.8 µs high time.
- BIT_CYC = SYSTEM_CLOCK/800000, a 1.25 µs bit period.
- RESET_CYC = SYSTEM_CLOCK/12500, an 80 µs latch.

Ports:
- clk_i  in  1  system clock; single clock domain, all logic on the rising edge.
- reset_i  in  1  asynchronous, active-high reset.
- start_i  in  1  frame start pulse, sampled only in IDLE.
- led_count_i  in  $clog2(NUM_LEDS)+1  number of pixels to send; sampled with start_i.
- busy_o  out  1  high while a frame, including the latch interval, is in progress.
- data_request_o  out  1  one-cycle pulse requesting the pixel at address_o.
- address_o  out  $clog2(NUM_LEDS)  index of the pixel being fetched or sent.
- red_i, green_i, blue_i  in  8 each  pixel colour, sampled one cycle after data_request_o.
- do_o  out  1  WS2812 data line, registered.

## Operation
- States: IDLE, FETCH1, FETCH2, REQ, LOAD, SEND, LATCH.
- IDLE:
  - start_i=1 with led_count_i≠0: latch n = min(led_count_i, NUM_LEDS), set address_o=0, go to FETCH1.
  - led_count_i=0: start_i is ignored.
- FETCH1 → FETCH2: two cycles for the synchronous RAM read of address_o.
- FETCH2 → REQ.
- REQ: data_request_o=1 for exactly this cycle; the upstream registers its colour outputs. Go to LOAD.
- LOAD: on the LOAD cycle's closing edge, load the 24-bit shift register with {green_i, red_i, blue_i}. Bit index = 23, cycle counter = 0. Go to SEND.
- SEND:
  - Bits go out MSB first: G7…G0, R7…R0, B7…B0.
  - For the current bit, do_o=1 for the first T1H_CYC (bit=1) or T0H_CYC (bit=0) cycles of the period, then 0 for the rest of BIT_CYC.
  - After 24 full periods: if address_o = n−1, go to LATCH; otherwise increment address_o and go to FETCH1.
- LATCH: do_o=0 for RESET_CYC cycles, then IDLE.
- start_i while not in IDLE is ignored.
- led_count_i changing mid-frame has no effect.
- Colour inputs are ignored except on the LOAD edge.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE; busy_o=0, data_request_o=0, address_o=0, do_o=0.
  - Shift register and all counters cleared.
- Reset mid-frame aborts the frame: do_o goes low immediately with no latch. The next start after release behaves normally.
- Let E0 be the edge that samples start_i:
  - busy_o=1 and address_o=0 from E0.
  - data_request_o high in the cycle after E2.
  - Colours sampled at E4.
  - do_o rises after E4.
- Per-pixel cost is 4 + 24·BIT_CYC cycles. do_o is low for 4 extra cycles before every pixel's first bit.
- address_o changes only on the FETCH1 entry edge. It is stable for 3 cycles before and during data_request_o.
- busy_o falls on the edge that enters IDLE, after RESET_CYC latch cycles.
- A start_i in the first IDLE cycle is accepted.
- Frame length in cycles = n·(4 + 24·BIT_CYC) + RESET_CYC. At 50 MHz: T0H=20, T1H=40, BIT=62, RESET=4000, per pixel=1492.
- Counter widths:
  - Cycle counter: $clog2(RESET_CYC+1) bits.
  - Bit index: 5 bits.
  - Clamp compare: led_count_i > NUM_LEDS, done at full led_count_i width.

## Test plan
- Reset asserted mid-SEND of LED 3 → all outputs 0 within the same cycle; after release, start with count=2 → normal 2-pixel frame with address_o 0,1.
- count=1, G=0xA5 R=0x3C B=0x0F → one data_request_o pulse at address 0. do_o high widths are 40,20,40,20,20,40,20,40 | 20,20,40,40,40,40,20,20 | 20,20,20,20,40,40,40,40 cycles, each period 62 cycles. busy_o high for exactly 5492 cycles.
- count=8, with the bench returning colour = address (G=R=B=k) → 8 data_request_o pulses with addresses 0..7 in order, 1492 cycles apart. Exactly 4 low cycles between pixels. busy_o high for 15936 cycles.
- count=0 with start pulse → busy_o stays 0 and do_o stays 0. count=12 (greater than NUM_LEDS=8) → frame clamped to 8 pixels.
- Second start_i pulses at cycle 100 and again during LATCH → ignored, with no extra data_request_o. A start on the first IDLE cycle after busy_o falls → new frame begins.
- Colour inputs toggled every cycle except on the LOAD edge → transmitted bits match only the values present on the LOAD edge.

Source files
------------

// File: rtl/ws2812_serializer.sv
// WS2812 single-wire serializer: fetches one GRB pixel per LED from the frame
// buffer through a request/address handshake and drives the bit waveform plus latch.
module ws2812_serializer #(
    parameter int NUM_LEDS     = 8,
    parameter int SYSTEM_CLOCK = 50000000
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        start_i,
    input  logic [$clog2(NUM_LEDS):0]   led_count_i,
    output logic                        busy_o,
    output logic                        data_request_o,
    output logic [$clog2(NUM_LEDS)-1:0] address_o,
    input  logic [7:0]                  red_i,
    input  logic [7:0]                  green_i,
    input  logic [7:0]                  blue_i,
    output logic                        do_o
);

    localparam int T0H_CYC   = SYSTEM_CLOCK / 2500000;
    localparam int T1H_CYC   = SYSTEM_CLOCK / 1250000;
    localparam int BIT_CYC   = SYSTEM_CLOCK / 800000;
    localparam int RESET_CYC = SYSTEM_CLOCK / 12500;

    localparam int AW   = $clog2(NUM_LEDS);
    localparam int CNTW = AW + 1;
    localparam int CW   = $clog2(RESET_CYC + 1);

    localparam logic [CW-1:0]   T0H      = CW'(T0H_CYC);
    localparam logic [CW-1:0]   T1H      = CW'(T1H_CYC);
    localparam logic [CW-1:0]   BIT_M1   = CW'(BIT_CYC - 1);
    localparam logic [CW-1:0]   RESET_M1 = CW'(RESET_CYC - 1);
    localparam logic [CNTW-1:0] MAX_LEDS = CNTW'(NUM_LEDS);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] FETCH1 = 3'd1;
    localparam logic [2:0] FETCH2 = 3'd2;
    localparam logic [2:0] REQ    = 3'd3;
    localparam logic [2:0] LOAD   = 3'd4;
    localparam logic [2:0] SEND   = 3'd5;
    localparam logic [2:0] LATCH  = 3'd6;

    logic [2:0]      state;
    logic [CNTW-1:0] n_q;
    logic [23:0]     shreg;
    logic [4:0]      bit_idx;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   th_cur;

    always_comb begin
        th_cur = shreg[23] ? T1H : T0H;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state          <= IDLE;
            n_q            <= '0;
            shreg          <= '0;
            bit_idx        <= '0;
            cnt            <= '0;
            busy_o         <= 1'b0;
            data_request_o <= 1'b0;
            address_o      <= '0;
            do_o           <= 1'b0;
        end else begin
            data_request_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (start_i && led_count_i != '0) begin
                        n_q       <= (led_count_i > MAX_LEDS) ? MAX_LEDS : led_count_i;
                        address_o <= '0;
                        busy_o    <= 1'b1;
                        state     <= FETCH1;
                    end
                end
                FETCH1: state <= FETCH2;
                FETCH2: begin
                    data_request_o <= 1'b1;
                    state          <= REQ;
                end
                REQ: state <= LOAD;
                LOAD: begin
                    shreg   <= {green_i, red_i, blue_i};
                    bit_idx <= 5'd23;
                    cnt     <= '0;
                    do_o    <= 1'b1;
                    state   <= SEND;
                end
                SEND: begin
                    // do_o is registered, so it is computed for the cycle about to start.
                    if (cnt == BIT_M1) begin
                        cnt <= '0;
                        if (bit_idx == 5'd0) begin
                            do_o <= 1'b0;
                            if ({1'b0, address_o} == n_q - CNTW'(1)) begin
                                state <= LATCH;
                            end else begin
                                address_o <= address_o + AW'(1);
                                state     <= FETCH1;
                            end
                        end else begin
                            bit_idx <= bit_idx - 5'd1;
                            shreg   <= {shreg[22:0], 1'b0};
                            do_o    <= 1'b1;
                        end
                    end else begin
                        cnt  <= cnt + CW'(1);
                        do_o <= (cnt + CW'(1)) < th_cur;
                    end
                end
                LATCH: begin
                    if (cnt == RESET_M1) begin
                        cnt    <= '0;
                        busy_o <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ws2812_serializer.sv
// Directed-sequence bench with randomized colours; expected waveform derived from
// the WS2812 bit timing rules and the requested pixel colours.
module tb_ws2812_serializer;

    localparam int T0H = 50000000 / 2500000;
    localparam int T1H = 50000000 / 1250000;
    localparam int BIT = 50000000 / 800000;
    localparam int RST = 50000000 / 12500;
    localparam int PIX = 4 + 24 * BIT;

    logic       clk = 1'b0;
    logic       reset_i = 1'b1;
    logic       start_i = 1'b0;
    logic [3:0] led_count_i = 4'd0;
    logic       busy_o, data_request_o, do_o;
    logic [2:0] address_o;
    logic [7:0] red_i = 8'd0, green_i = 8'd0, blue_i = 8'd0;

    ws2812_serializer #(.NUM_LEDS(8), .SYSTEM_CLOCK(50000000)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i), .led_count_i(led_count_i),
        .busy_o(busy_o), .data_request_o(data_request_o), .address_o(address_o),
        .red_i(red_i), .green_i(green_i), .blue_i(blue_i), .do_o(do_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    int aq[$];
    int rc[$];
    int rq[$];
    int hq[$];
    int cyc = 0, busy_cyc = 0, hi_cyc = 0, run = 0;
    bit prev_do = 1'b0;
    bit toggle = 1'b0;
    bit req_prev = 1'b0;
    int req_addr = 0;
    logic [7:0] cg[8], cr[8], cb[8];

    // Upstream model: colours valid in the cycle after the request, junk otherwise when toggling.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (req_prev) begin
                green_i = cg[req_addr];
                red_i   = cr[req_addr];
                blue_i  = cb[req_addr];
            end else if (toggle) begin
                green_i = 8'($urandom);
                red_i   = 8'($urandom);
                blue_i  = 8'($urandom);
            end
            req_prev = data_request_o;
            req_addr = int'(address_o);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (busy_o) busy_cyc++;
            if (do_o) hi_cyc++;
            if (data_request_o) begin
                aq.push_back(int'(address_o));
                rc.push_back(cyc);
            end
            if (do_o && !prev_do) rq.push_back(cyc);
            if (do_o) run++;
            else if (prev_do) begin
                hq.push_back(run);
                run = 0;
            end
            prev_do = do_o;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        aq.delete(); rc.delete(); rq.delete(); hq.delete();
        busy_cyc = 0; hi_cyc = 0;
    endtask

    task automatic set_colours(input bit by_addr);
        for (int i = 0; i < 8; i++) begin
            cg[i] = by_addr ? 8'(i) : 8'($urandom);
            cr[i] = by_addr ? 8'(i) : 8'($urandom);
            cb[i] = by_addr ? 8'(i) : 8'($urandom);
        end
    endtask

    task automatic start_pulse(input int cnt);
        @(negedge clk); #1;
        clear_mon();
        led_count_i = 4'(cnt);
        start_i = 1'b1;
        @(negedge clk); #1;
        start_i = 1'b0;
        led_count_i = 4'($urandom_range(0, 15));
    endtask

    task automatic spurious_start();
        led_count_i = 4'd8;
        start_i = 1'b1;
        @(negedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic wait_idle();
        int k = 0;
        do begin
            @(negedge clk); #1;
            k++;
        end while (busy_o && k < 30000);
        check("frame_ends", int'(busy_o), 0);
    endtask

    task automatic check_frame(input int n);
        logic [23:0] w;
        int exp_w;
        if (n == 0) begin
            check("idle_busy", busy_cyc, 0);
            check("idle_do", hi_cyc, 0);
            check("idle_req", aq.size(), 0);
            return;
        end
        check("busy_len", busy_cyc, n * PIX + RST);
        check("req_count", aq.size(), n);
        for (int i = 0; i < aq.size() && i < n; i++) begin
            check("req_addr", aq[i], i);
            if (i > 0) check("req_gap", rc[i] - rc[i-1], PIX);
        end
        check("bit_count", hq.size(), 24 * n);
        for (int k = 0; k < hq.size() && k < 24 * n; k++) begin
            w = {cg[k/24], cr[k/24], cb[k/24]};
            exp_w = w[23 - (k % 24)] ? T1H : T0H;
            check("high_width", hq[k], exp_w);
        end
        for (int k = 1; k < rq.size() && k < 24 * n; k++)
            check("bit_period", rq[k] - rq[k-1], (k % 24 == 0) ? BIT + 4 : BIT);
        if (rq.size() > 0 && rc.size() > 0) check("first_rise", rq[0] - rc[0], 2);
    endtask

    initial begin
        int n, k;
        #12;
        check("rst_busy", int'(busy_o), 0);
        check("rst_req", int'(data_request_o), 0);
        check("rst_addr", int'(address_o), 0);
        check("rst_do", int'(do_o), 0);
        @(negedge clk); #1;
        reset_i = 1'b0;

        // Single pixel, fixed colour
        set_colours(1'b0);
        cg[0] = 8'hA5; cr[0] = 8'h3C; cb[0] = 8'h0F;
        start_pulse(1);
        wait_idle();
        check_frame(1);

        // Full frame, colour = address, with starts during SEND and LATCH
        set_colours(1'b1);
        start_pulse(8);
        repeat (97) @(negedge clk);
        #1;
        spurious_start();
        k = 0;
        while (rq.size() < 192 && k < 20000) begin
            @(negedge clk); #1;
            k++;
        end
        repeat (200) @(negedge clk);
        #1;
        spurious_start();
        wait_idle();
        check_frame(8);

        // Start on the first IDLE cycle after busy falls
        set_colours(1'b0);
        n = $urandom_range(1, 3);
        clear_mon();
        led_count_i = 4'(n);
        start_i = 1'b1;
        @(negedge clk); #1;
        start_i = 1'b0;
        check("restart_busy", int'(busy_o), 1);
        wait_idle();
        check_frame(n);

        // Zero count ignored
        start_pulse(0);
        repeat (200) @(negedge clk);
        check_frame(0);

        // Over-range count clamps to NUM_LEDS
        set_colours(1'b0);
        start_pulse(12);
        wait_idle();
        check_frame(8);

        // Colour inputs toggling outside the LOAD edge
        set_colours(1'b0);
        n = $urandom_range(2, 4);
        toggle = 1'b1;
        start_pulse(n);
        wait_idle();
        toggle = 1'b0;
        check_frame(n);

        // Reset while LED 3 is being sent
        set_colours(1'b1);
        start_pulse(8);
        k = 0;
        while (aq.size() < 4 && k < 20000) begin
            @(negedge clk); #1;
            k++;
        end
        repeat (300) @(negedge clk);
        #1;
        k = 0;
        while (!do_o && k < 200) begin
            @(negedge clk); #1;
            k++;
        end
        check("pre_reset_do", int'(do_o), 1);
        reset_i = 1'b1;
        #1;
        check("abort_busy", int'(busy_o), 0);
        check("abort_req", int'(data_request_o), 0);
        check("abort_addr", int'(address_o), 0);
        check("abort_do", int'(do_o), 0);
        repeat (3) @(negedge clk);
        #1;
        reset_i = 1'b0;
        repeat (5) @(negedge clk);
        set_colours(1'b0);
        start_pulse(2);
        wait_idle();
        check_frame(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
